// File: rtl/trans_sequencer_if.sv
// Request channel between the test sequencer and the memory-checker transmitter.
interface trans_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              trans_valid;
  logic [ADDR_W-1:0] trans_addr;
  logic              trans_type;   // 0 = write, 1 = read
  logic              trans_ready;
  logic              trans_busy;

  modport master (
    output trans_valid, trans_addr, trans_type,
    input  trans_ready, trans_busy
  );

  modport slave (
    input  trans_valid, trans_addr, trans_type,
    output trans_ready, trans_busy
  );
endinterface

// File: rtl/trans_sequencer.sv
// Test-level sequencer: issues write/read/write-then-read requests over fixed, running or
// LFSR-random addresses, counts accepted handshakes and reports completion/error status.
// Optional watchdog and timeout_o port are enabled by defining SEQ_TIMEOUT_EN.
module trans_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        test_mode_i,
  input  logic [1:0]        addr_mode_i,
  input  logic [CNT_W-1:0]  trans_cnt_i,
  input  logic [ADDR_W-1:0] addr_low_i,
  input  logic [ADDR_W-1:0] addr_high_i,
  input  logic [ADDR_W-1:0] addr_step_i,
  input  logic [ADDR_W-1:0] addr_mask_i,
  trans_sequencer_if.master trans_io,
  input  logic              cmp_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
`ifdef SEQ_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic [CNT_W-1:0]  sent_cnt_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [1:0]  TmWrite   = 2'd1;
  localparam logic [1:0]  TmWac     = 2'd2;
  localparam logic [1:0]  AmRun     = 2'd1;
  localparam logic [1:0]  AmRnd     = 2'd2;
  // Galois feedback for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;

  state_e            state_q, state_d;
  logic [1:0]        test_mode_q, test_mode_d;
  logic [1:0]        addr_mode_q, addr_mode_d;
  logic [ADDR_W-1:0] low_q, low_d, high_q, high_d, step_q, step_d, mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              type_q, type_d;
  logic [CNT_W-1:0]  unit_cnt_q, unit_cnt_d;
  logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              error_q, error_d;

  logic              hs, wac, unit_done;
  logic [31:0]       lfsr_step;
  logic [ADDR_W:0]   run_sum;
  logic              run_wrap;
  logic [ADDR_W-1:0] addr_next;

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;
  logic                 wd_expired;
  assign wd_expired = &wd_q;
`else
  logic [TIMEOUT_W-1:0] unused_wd;
  assign unused_wd = '0;
`endif

  assign hs        = (state_q == StIssue) && trans_io.trans_ready;
  assign wac       = (test_mode_q == TmWac);
  // In write-and-check the unit ends on its read half, which type_q tracks.
  assign unit_done = hs && (!wac || type_q);
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
  assign run_sum   = {1'b0, addr_q} + {1'b0, step_q};
  assign run_wrap  = run_sum[ADDR_W] || (run_sum[ADDR_W-1:0] > high_q);

  // Address of the following unit.
  always_comb begin
    addr_next = low_q;
    if (addr_mode_q == AmRun) begin
      addr_next = run_wrap ? low_q : run_sum[ADDR_W-1:0];
    end else if (addr_mode_q == AmRnd) begin
      addr_next = ADDR_W'(lfsr_step) & mask_q;
    end
  end

  // Next-state logic for the control FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    test_mode_d = test_mode_q;
    addr_mode_d = addr_mode_q;
    low_d       = low_q;
    high_d      = high_q;
    step_d      = step_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    type_d      = type_q;
    unit_cnt_d  = unit_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    lfsr_d      = lfsr_q;
    error_d     = error_q;
`ifdef SEQ_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          test_mode_d = test_mode_i;
          addr_mode_d = addr_mode_i;
          low_d       = addr_low_i;
          high_d      = addr_high_i;
          step_d      = addr_step_i;
          mask_d      = addr_mask_i;
          unit_cnt_d  = trans_cnt_i;
          sent_cnt_d  = '0;
          error_d     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          addr_d      = (addr_mode_i == AmRnd) ? (ADDR_W'(lfsr_q) & addr_mask_i) : addr_low_i;
          // Write-only and write-and-check begin with a write; everything else reads.
          type_d      = !((test_mode_i == TmWrite) || (test_mode_i == TmWac));
          state_d     = (trans_cnt_i == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (hs && wac) type_d = ~type_q;
        if (unit_done) begin
          unit_cnt_d = unit_cnt_q - CNT_W'(1);
          addr_d     = addr_next;
          if (addr_mode_q == AmRnd) lfsr_d = lfsr_step;
          if (unit_cnt_q == CNT_W'(1)) state_d = StDrain;
        end
        if (cmp_error_i) state_d = StDrain;
      end
      StDrain: begin
        if (!trans_io.trans_busy) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (hs && !(&sent_cnt_q)) sent_cnt_d = sent_cnt_q + CNT_W'(1);
    if (cmp_error_i && (state_q != StIdle)) error_d = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    if (wd_expired && ((state_q == StIssue) || (state_q == StDrain))) begin
      state_d   = StDone;
      timeout_d = 1'b1;
    end
`endif
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counts stalled cycles and restarts on any handshake or state change.
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) && !hs) begin
      if (((state_q == StIssue) && !trans_io.trans_ready) ||
          ((state_q == StDrain) && trans_io.trans_busy)) begin
        wd_d = wd_q + TIMEOUT_W'(1);
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      test_mode_q <= '0;
      addr_mode_q <= '0;
      low_q       <= '0;
      high_q      <= '0;
      step_q      <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      type_q      <= 1'b0;
      unit_cnt_q  <= '0;
      sent_cnt_q  <= '0;
      lfsr_q      <= '1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      test_mode_q <= test_mode_d;
      addr_mode_q <= addr_mode_d;
      low_q       <= low_d;
      high_q      <= high_d;
      step_q      <= step_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      unit_cnt_q  <= unit_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      lfsr_q      <= lfsr_d;
      error_q     <= error_d;
    end
  end

  assign trans_io.trans_valid = (state_q == StIssue);
  assign trans_io.trans_addr  = addr_q;
  assign trans_io.trans_type  = type_q;
  assign busy_o               = (state_q != StIdle);
  assign done_o               = (state_q == StDone);
  assign error_o              = error_q;
  assign sent_cnt_o           = sent_cnt_q;

endmodule

// File: tb/tb_trans_sequencer.sv
// Randomized bench for trans_sequencer with a transaction-list reference model.
module tb_trans_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    test_mode, addr_mode;
  logic [CW-1:0] trans_cnt;
  logic [AW-1:0] addr_low, addr_high, addr_step, addr_mask;
  logic          cmp_error;
  logic          dut_busy, done, error;
  logic [CW-1:0] sent;
`ifdef SEQ_TIMEOUT_EN
  logic          timeout;
`endif

  trans_sequencer_if #(.ADDR_W(AW)) tif ();

  trans_sequencer #(.ADDR_W(AW), .CNT_W(CW), .TIMEOUT_W(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .test_mode_i (test_mode),
    .addr_mode_i (addr_mode),
    .trans_cnt_i (trans_cnt),
    .addr_low_i  (addr_low),
    .addr_high_i (addr_high),
    .addr_step_i (addr_step),
    .addr_mask_i (addr_mask),
    .trans_io    (tif),
    .cmp_error_i (cmp_error),
    .busy_o      (dut_busy),
    .done_o      (done),
    .error_o     (error),
`ifdef SEQ_TIMEOUT_EN
    .timeout_o   (timeout),
`endif
    .sent_cnt_o  (sent)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] lfsr_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic run_test(input logic [1:0] tm, input logic [1:0] am, input int cnt,
                          input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] st,
                          input logic [31:0] mk, input int rdy_mode, input int err_after);
    logic [31:0] exp_addr[$];
    logic        exp_type[$];
    logic [31:0] a, l, ad, prev_addr;
    logic        prev_type, prev_stall, r, err_sent, drain_err, exp_err;
    longint      s;
    int          upu, n, cyc, hold;

    // Expected request list: one entry per handshake.
    upu = (tm == 2'd2) ? 2 : 1;
    a = lo;
    l = lfsr_m;
    for (int u = 0; u < cnt; u++) begin
      case (am)
        2'd1:    ad = a;
        2'd2:    ad = l & mk;
        default: ad = lo;
      endcase
      if (upu == 2) begin
        exp_addr.push_back(ad); exp_type.push_back(1'b0);
        exp_addr.push_back(ad); exp_type.push_back(1'b1);
      end else begin
        exp_addr.push_back(ad); exp_type.push_back(tm != 2'd1);
      end
      l = lfsr_next(l);
      s = longint'(a) + longint'(st);
      a = (s > longint'(hi) || s > 64'h0000_0000_FFFF_FFFF) ? lo : s[31:0];
    end

    @(negedge clk);
    test_mode = tm; addr_mode = am; trans_cnt = CW'(cnt);
    addr_low = lo; addr_high = hi; addr_step = st; addr_mask = mk;
    start = 1'b1;
    tif.trans_busy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Parameters must have been captured at start.
    test_mode = 2'($urandom); addr_mode = 2'($urandom); trans_cnt = CW'($urandom);
    addr_low = $urandom; addr_high = $urandom; addr_step = $urandom; addr_mask = $urandom;
    check_eq("start_busy", dut_busy, 1'b1);
    check_eq("start_sent_clr", sent, 0);
    check_eq("start_err_clr", error, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    check_eq("start_to_clr", timeout, 1'b0);
`endif
    check_eq("first_valid", tif.trans_valid, cnt != 0);

    n = 0; cyc = 0; prev_stall = 1'b0; err_sent = 1'b0;
    prev_addr = '0; prev_type = 1'b0;
    forever begin
      if (err_sent || !tif.trans_valid) break;
      if (cyc >= 2000) begin
        check_eq("issue_bound", tif.trans_valid, 1'b0);
        break;
      end
      if (prev_stall) begin
        check_eq("stall_addr", tif.trans_addr, prev_addr);
        check_eq("stall_type", tif.trans_type, prev_type);
      end
      check_eq("sent_run", sent, sat(n));
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (err_after > 0 && n == err_after) begin
        cmp_error = 1'b1;
        err_sent  = 1'b1;
      end
      tif.trans_ready = r;
      if (r) begin
        if (n < exp_addr.size()) begin
          check_eq("req_addr", tif.trans_addr, exp_addr[n]);
          check_eq("req_type", tif.trans_type, exp_type[n]);
        end else begin
          check_eq("extra_accept", n, exp_addr.size());
        end
        n++;
      end
      prev_stall = !r;
      prev_addr  = tif.trans_addr;
      prev_type  = tif.trans_type;
      @(negedge clk);
      cmp_error = 1'b0;
      tif.trans_ready = 1'b0;
      cyc++;
    end

    if (err_sent) begin
      check_eq("err_valid_drop", tif.trans_valid, 1'b0);
      check_eq("err_accepts", (n == err_after) || (n == err_after + 1), 1'b1);
    end else begin
      check_eq("accepts", n, exp_addr.size());
      if (rdy_mode == 0) check_eq("b2b_cycles", cyc, exp_addr.size());
    end
    if (am == 2'd2) begin
      for (int k = 0; k < n / upu; k++) lfsr_m = lfsr_next(lfsr_m);
    end

    // Transmitter stays busy a little; stray start and optional late error meanwhile.
    hold      = $urandom_range(0, 3);
    drain_err = (hold > 0) && ($urandom_range(0, 3) == 0);
    exp_err   = err_sent || drain_err;
    for (int h = 0; h < hold; h++) begin
      check_eq("drain_no_done", done, 1'b0);
      check_eq("drain_busy", dut_busy, 1'b1);
      if (h == 0) begin
        start     = 1'b1;
        trans_cnt = '0;
        cmp_error = drain_err;
      end
      @(negedge clk);
      start     = 1'b0;
      cmp_error = 1'b0;
    end
    tif.trans_busy = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_sent", sent, sat(n));
    check_eq("done_error", error, exp_err);
    @(negedge clk);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_busy", dut_busy, 1'b0);
    cmp_error = 1'b1;
    @(negedge clk);
    cmp_error = 1'b0;
    check_eq("idle_err_ignored", error, exp_err);
  endtask

  initial begin
    logic [1:0]  tm, am;
    logic [31:0] lo, hi, st, mk;
    int          cnt, tot, ea;

    rst = 1'b1; start = 1'b0; cmp_error = 1'b0;
    test_mode = '0; addr_mode = '0; trans_cnt = '0;
    addr_low = '0; addr_high = '0; addr_step = '0; addr_mask = '0;
    tif.trans_ready = 1'b0; tif.trans_busy = 1'b0;
    lfsr_m = 32'hFFFF_FFFF;
    #1;
    check_eq("rst_valid", tif.trans_valid, 1'b0);
    check_eq("rst_addr", tif.trans_addr, 0);
    check_eq("rst_type", tif.trans_type, 1'b0);
    check_eq("rst_busy", dut_busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_sent", sent, 0);
    @(negedge clk);
    rst = 1'b0;

    run_test(2'd1, 2'd1, 5, 32'h100, 32'h130, 32'h10, 32'h0, 0, 0);
    run_test(2'd2, 2'd0, 2, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0);
    run_test(2'd0, 2'd0, 3, 32'h80, 32'h0, 32'h0, 32'h0, 1, 0);
    run_test(2'd2, 2'd1, 10, 32'h200, 32'h2F0, 32'h20, 32'h0, 0, 3);
    run_test(2'd1, 2'd0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0);
    run_test(2'd0, 2'd2, 4, 32'h0, 32'h0, 32'h0, 32'hFF0, 0, 0);
    run_test(2'd3, 2'd1, 6, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h60, 32'h0, 2, 0);
    run_test(2'd2, 2'd3, 200, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
    @(negedge clk);
    test_mode = 2'd1; addr_mode = 2'd0; trans_cnt = CW'(3); start = 1'b1;
    tif.trans_busy = 1'b1; tif.trans_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (tif.trans_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("to_done", done, 1'b1);
    check_eq("to_flag", timeout, 1'b1);
    check_eq("to_cycles", (cnt >= 2 ** TW - 1) && (cnt <= 2 ** TW), 1'b1);
    tif.trans_busy = 1'b0;
    @(negedge clk);
    check_eq("to_idle", dut_busy, 1'b0);
`endif

    for (int t = 0; t < 30; t++) begin
      tm  = 2'($urandom);
      am  = 2'($urandom);
      cnt = $urandom_range(0, 12);
      lo  = $urandom;
      hi  = lo + $urandom_range(0, 32'h200);
      st  = $urandom_range(0, 32'h80);
      mk  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        lo = 32'hFFFF_FF00 + $urandom_range(0, 32'h40);
        hi = 32'hFFFF_FFFF;
      end
      tot = cnt * ((tm == 2'd2) ? 2 : 1);
      ea  = (tot >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, tot - 1) : 0;
      run_test(tm, am, cnt, lo, hi, st, mk, 2, ea);
    end

    // Asynchronous reset in the middle of a random-address run.
    @(negedge clk);
    test_mode = 2'd0; addr_mode = 2'd2; trans_cnt = CW'(8); addr_mask = 32'hFFFF;
    start = 1'b1; tif.trans_busy = 1'b1; tif.trans_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", tif.trans_valid, 1'b0);
    check_eq("mid_rst_addr", tif.trans_addr, 0);
    check_eq("mid_rst_busy", dut_busy, 1'b0);
    check_eq("mid_rst_sent", sent, 0);
    check_eq("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tif.trans_ready = 1'b0;
    tif.trans_busy  = 1'b0;
    lfsr_m = 32'hFFFF_FFFF;
    run_test(2'd1, 2'd2, 4, 32'h0, 32'h0, 32'h0, 32'hFF0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
